// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin lock arbiter.
//   clog2   : ceiling log2, usable in parameter expressions
//   calc_cw : chosen-index width, never less than 1 bit
// The skid entry {bits, last, chosen} is declared in the arbiter itself.
// Its widths follow the instance parameters, and a package typedef
// cannot be parameterised.
package rr_arb_pkg;

    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) result++;
        return result;
    endfunction

    function automatic int calc_cw(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry registered FIFO stage. Data comes out of flops only, so the
// consumer ready never reaches back into the producer side combinationally.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   in_valid, in_data   : push side (push is ignored while full)
//   full                : both entries occupied
//   out_valid, out_data : head entry
//   out_ready           : pops the head
module skid_buffer2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          full,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic [1:0]    count_q;
    logic          push;
    logic          pop;

    assign full      = (count_q == 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & ~full;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= in_data;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= in_data;
                    end else if (push) begin
                        tail_q  <= in_data;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                    end
                end
                default: count_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter merging N producer channels onto one consumer.
// Multi-beat bursts can hold the grant, and a registered 2-entry output
// stage sits between the arbiter and the consumer.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   unlocked | round-robin among valid channels, starting after ptr
//   locked   | only lock_ch may be granted (entered on a last=0 beat)
//
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   io_in_valid/ready/bits/last   : N producer channels, bits packed i*W
//   io_out_valid/ready/bits/last  : consumer port (registered outputs)
//   io_chosen                     : source channel of the head beat
module rr_lock_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter bit LOCK_EN = 1'b1,
    localparam int CW     = calc_cw(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   io_in_valid,
    output logic [N-1:0]   io_in_ready,
    input  logic [N*W-1:0] io_in_bits,
    input  logic [N-1:0]   io_in_last,
    input  logic           io_out_ready,
    output logic           io_out_valid,
    output logic [W-1:0]   io_out_bits,
    output logic           io_out_last,
    output logic [CW-1:0]  io_chosen
);

    typedef struct packed {
        logic [W-1:0]  bits;
        logic          last;
        logic [CW-1:0] chosen;
    } skid_entry_t;

    logic [CW-1:0] ptr;
    logic          lock;
    logic [CW-1:0] lock_ch;
    logic          full;
    logic          grant_vld;
    logic [CW-1:0] grant_idx;
    logic          hi_found;
    logic [CW-1:0] hi_idx;
    logic          lo_found;
    logic [CW-1:0] lo_idx;
    logic          lock_valid;
    logic          accept;
    skid_entry_t   push_entry;
    skid_entry_t   head_entry;

    // Both scans run from the top down, so the last hit is the lowest index.
    always_comb begin
        hi_found   = 1'b0;
        hi_idx     = '0;
        lo_found   = 1'b0;
        lo_idx     = '0;
        lock_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (io_in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = CW'(i);
                if (i > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = CW'(i);
                end
            end
            if (CW'(i) == lock_ch) lock_valid = io_in_valid[i];
        end
    end

    // An idle lock owner still blocks everyone else.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (lock) begin
            grant_vld = lock_valid;
            grant_idx = lock_ch;
        end else if (hi_found) begin
            grant_vld = 1'b1;
            grant_idx = hi_idx;
        end else begin
            grant_vld = lo_found;
            grant_idx = lo_idx;
        end
    end

    always_comb begin
        io_in_ready = '0;
        push_entry  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == CW'(i)) begin
                io_in_ready[i]  = grant_vld & ~full;
                push_entry.bits = io_in_bits[i*W +: W];
                push_entry.last = io_in_last[i];
            end
        end
        push_entry.chosen = grant_idx;
    end

    // grant_vld already implies the granted channel is valid.
    assign accept = grant_vld & ~full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (accept) begin
            if (push_entry.last || !LOCK_EN) begin
                ptr  <= grant_idx;
                lock <= 1'b0;
            end else begin
                lock    <= 1'b1;
                lock_ch <= grant_idx;
            end
        end
    end

    skid_buffer2 #(
        .DW ($bits(skid_entry_t))
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (accept),
        .in_data   (push_entry),
        .full      (full),
        .out_valid (io_out_valid),
        .out_ready (io_out_ready),
        .out_data  (head_entry)
    );

    assign io_out_bits = head_entry.bits;
    assign io_out_last = head_entry.last;
    assign io_chosen   = head_entry.chosen;

endmodule
